// File: rtl/sqm_result_buffer.sv
// -----------------------------------------------------------------------------
// sqm_result_buffer
//
// Purpose:
//   Small first-word-fall-through FIFO that sits behind the square-mod /
//   bit-select unit and its max-run-length priority encoder. Each accepted
//   {Y, Z} pair (datapath result, longest-ones-run length) is stored so the
//   consumer can stall without losing results. Alongside the FIFO the block
//   keeps statistics over accepted pairs:
//   - the largest Z seen and the Y that came with it;
//   - a saturating count of accepted pairs;
//   - a sticky flag for run lengths that cannot occur in a DATA_W-bit word.
//
// Ports:
//   clk        : single clock, all state updates on its rising edge
//   reset      : asynchronous, active-high reset
//   in_valid   : upstream pair valid
//   in_ready   : buffer can accept a pair (depends on registered state only)
//   in_y/in_z  : upstream pair
//   out_valid  : head entry available
//   out_ready  : consumer takes the head entry
//   out_y/out_z: head entry, forced to 0 while out_valid is low
//   count      : occupancy, 0..DEPTH
//   clr_stats  : synchronous clear of the statistics
//   max_z      : largest Z accepted since the last clear
//   max_y      : Y accompanying max_z
//   total      : accepted-pair count, saturating
//   err_len    : sticky, set when an accepted Z exceeds DATA_W
//
// Handshake (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   valid, once raised, must hold with stable data until the transfer.
//   ready never depends combinationally on valid or on the other side's
//   ready: in_ready comes from occupancy only, so a pop on a full buffer
//   does not open a slot for a push in the same cycle.
// -----------------------------------------------------------------------------
module sqm_result_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_y,
    input  logic [LEN_W-1:0]          in_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_y,
    output logic [LEN_W-1:0]          out_z,
    output logic [$clog2(DEPTH):0]    count,
    input  logic                      clr_stats,
    output logic [LEN_W-1:0]          max_z,
    output logic [DATA_W-1:0]         max_y,
    output logic [CNT_W-1:0]          total,
    output logic                      err_len
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Storage. Contents are not reset: the outputs are masked by out_valid,
    // so stale entries are never visible.
    logic [DATA_W-1:0] mem_y [DEPTH];
    logic [LEN_W-1:0]  mem_z [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              push;
    logic              pop;

    // Next-state values for the statistics
    logic [LEN_W-1:0]  base_max_z;
    logic [DATA_W-1:0] base_max_y;
    logic [CNT_W-1:0]  base_total;
    logic              base_err;
    logic [LEN_W-1:0]  nxt_max_z;
    logic [DATA_W-1:0] nxt_max_y;
    logic [CNT_W-1:0]  nxt_total;
    logic              nxt_err;
    logic              z_illegal;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    assign in_ready  = (count != OCC_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // First-word fall-through from storage, zero while empty
    assign out_y = out_valid ? mem_y[rd_ptr] : '0;
    assign out_z = out_valid ? mem_z[rd_ptr] : '0;

    // -------------------------------------------------------------------------
    // Storage write (no reset needed, see above)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_y[wr_ptr] <= in_y;
            mem_z[wr_ptr] <= in_z;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // naturally; full vs empty is told apart by count, never by pointers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Statistics. A clear is applied first, then the accepted push is folded
    // in on top of the cleared values, so clear+push leaves exactly that
    // pair's contribution.
    // -------------------------------------------------------------------------
    // A run of ones longer than the word itself is impossible upstream.
    assign z_illegal = (32'(in_z) > 32'(DATA_W));

    always_comb begin
        base_max_z = clr_stats ? '0   : max_z;
        base_max_y = clr_stats ? '0   : max_y;
        base_total = clr_stats ? '0   : total;
        base_err   = clr_stats ? 1'b0 : err_len;

        nxt_max_z  = base_max_z;
        nxt_max_y  = base_max_y;
        nxt_total  = base_total;
        nxt_err    = base_err;

        if (push) begin
            // Strictly greater: on a tie the earlier pair is kept
            if (in_z > base_max_z) begin
                nxt_max_z = in_z;
                nxt_max_y = in_y;
            end
            if (base_total != '1) begin
                nxt_total = base_total + CNT_W'(1);
            end
            if (z_illegal) begin
                nxt_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_z   <= '0;
            max_y   <= '0;
            total   <= '0;
            err_len <= 1'b0;
        end else begin
            max_z   <= nxt_max_z;
            max_y   <= nxt_max_y;
            total   <= nxt_total;
            err_len <= nxt_err;
        end
    end

endmodule

// File: tb/tb_sqm_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_sqm_result_buffer
//
// Bench for sqm_result_buffer. A queue holds the expected FIFO contents and
// plain variables hold the expected statistics; both are updated from the
// handshake rules each clock and compared against every DUT output.
// -----------------------------------------------------------------------------
module tb_sqm_result_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;
    localparam int CNT_W  = 16;
    localparam int OCC_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_y;
    logic [LEN_W-1:0]  in_z;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_y;
    logic [LEN_W-1:0]  out_z;
    logic [OCC_W-1:0]  count;
    logic              clr_stats;
    logic [LEN_W-1:0]  max_z;
    logic [DATA_W-1:0] max_y;
    logic [CNT_W-1:0]  total;
    logic              err_len;

    sqm_result_buffer #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_y     (in_y),
        .in_z     (in_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_z    (out_z),
        .count    (count),
        .clr_stats(clr_stats),
        .max_z    (max_z),
        .max_y    (max_y),
        .total    (total),
        .err_len  (err_len)
    );

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -------------------------------------------------------------------------
    // Reference model: expected queue of {y, z} plus expected statistics
    // -------------------------------------------------------------------------
    logic [DATA_W+LEN_W-1:0] exp_q[$];
    int                      m_max_z;
    int                      m_max_y;
    int                      m_total;
    int                      m_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_max_z = 0;
        m_max_y = 0;
        m_total = 0;
        m_err   = 0;
    endtask

    task automatic check_outputs();
        int exp_y;
        int exp_z;
        exp_y = 0;
        exp_z = 0;
        if (exp_q.size() != 0) begin
            exp_y = int'(exp_q[0][DATA_W+LEN_W-1:LEN_W]);
            exp_z = int'(exp_q[0][LEN_W-1:0]);
        end
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("in_ready",  32'(in_ready),  32'(exp_q.size() != DEPTH));
        check("count",     32'(count),     32'(exp_q.size()));
        check("out_y",     32'(out_y),     32'(exp_y));
        check("out_z",     32'(out_z),     32'(exp_z));
        check("max_z",     32'(max_z),     32'(m_max_z));
        check("max_y",     32'(max_y),     32'(m_max_y));
        check("total",     32'(total),     32'(m_total));
        check("err_len",   32'(err_len),   32'(m_err));
    endtask

    // One clock: decide transfers from the pre-edge inputs and expected
    // occupancy, advance the model, then compare after the edge.
    task automatic step();
        bit do_push;
        bit do_pop;
        do_push = in_valid && (exp_q.size() != DEPTH);
        do_pop  = out_ready && (exp_q.size() != 0);
        @(posedge clk);
        if (do_pop) void'(exp_q.pop_front());
        if (clr_stats) begin
            m_max_z = 0;
            m_max_y = 0;
            m_total = 0;
            m_err   = 0;
        end
        if (do_push) begin
            exp_q.push_back({in_y, in_z});
            if (int'(in_z) > m_max_z) begin
                m_max_z = int'(in_z);
                m_max_y = int'(in_y);
            end
            if (m_total < (2 ** CNT_W) - 1) m_total++;
            if (int'(in_z) > DATA_W) m_err = 1;
        end
        #1;
        check_outputs();
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic drive(input bit v, input logic [DATA_W-1:0] y, input logic [LEN_W-1:0] z,
                         input bit rdy, input bit clr);
        in_valid  = v;
        in_y      = y;
        in_z      = z;
        out_ready = rdy;
        clr_stats = clr;
    endtask

    task automatic drain();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step();
        end
        check("drain_empty", 32'(count), 32'd0);
        out_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] fill_y [4];
    logic [LEN_W-1:0]  fill_z [4];

    initial begin
        fill_y[0] = 8'h0F; fill_z[0] = 4'd4;
        fill_y[1] = 8'hFF; fill_z[1] = 4'd8;
        fill_y[2] = 8'h01; fill_z[2] = 4'd1;
        fill_y[3] = 8'h6E; fill_z[3] = 4'd3;

        drive(1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Fill to full with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_y[i], fill_z[i], 1'b0, 1'b0);
            step();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'hAA, 4'd1, 1'b0, 1'b0);
        step();
        check("full_held_count", 32'(count), 32'd4);
        // Pop the four entries in order
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("pop_order_y", 32'(out_y), 32'(fill_y[i]));
            check("pop_order_z", 32'(out_z), 32'(fill_z[i]));
            step();
        end
        check("pop_empty", 32'(out_valid), 32'd0);

        // Simultaneous push/pop at count = 2, pointers wrap
        drive(1'b1, 8'h20, 4'd1, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h21, 4'd2, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            check("stream_head_y", 32'(out_y), 32'h20 + 32'(i));
            drive(1'b1, 8'(8'h22 + i), 4'(i), 1'b1, 1'b0);
            step();
            check("stream_count", 32'(count), 32'd2);
        end
        drain();

        // Max tracking, ties keep the first pair
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        step();
        drive(1'b1, 8'h11, 4'd2, 1'b1, 1'b0); step();
        drive(1'b1, 8'h7C, 4'd5, 1'b1, 1'b0); step();
        drive(1'b1, 8'h3E, 4'd5, 1'b1, 1'b0); step();
        drive(1'b1, 8'h42, 4'd3, 1'b1, 1'b0); step();
        check("maxtrk_max_z", 32'(max_z), 32'd5);
        check("maxtrk_max_y", 32'(max_y), 32'h7C);
        check("maxtrk_total", 32'(total), 32'd4);
        drain();

        // Illegal run length, then clear coinciding with a push
        drive(1'b1, 8'h55, 4'd9, 1'b1, 1'b0);
        step();
        check("err_set", 32'(err_len), 32'd1);
        drive(1'b1, 8'h06, 4'd2, 1'b1, 1'b1);
        step();
        check("clrpush_max_z", 32'(max_z), 32'd2);
        check("clrpush_max_y", 32'(max_y), 32'h06);
        check("clrpush_total", 32'(total), 32'd1);
        check("clrpush_err", 32'(err_len), 32'd0);
        drain();

        // Empty pass-through with the consumer always ready
        drive(1'b1, 8'h80, 4'd1, 1'b1, 1'b0);
        step();
        check("pass_valid", 32'(out_valid), 32'd1);
        check("pass_y", 32'(out_y), 32'h80);
        check("pass_z", 32'(out_z), 32'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        check("pass_count", 32'(count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            step();
        end

        // Asynchronous reset mid-stream with three entries held
        drain();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h90 + i), 4'(i + 2), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("pre_reset_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'hC3, 4'd7, 1'b1, 1'b0);
        step();
        check("post_reset_y", 32'(out_y), 32'hC3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sqm_result_buffer.md
Name: sqm_result_buffer

Overview:
- Downstream stage of the square-mod / bit-select unit with its max-run-length priority encoder.
- Captures each {Y, Z} result pair (8-bit datapath result, 4-bit longest-ones-run length) into a small FIFO behind a valid/ready handshake, so the consumer (register writeback or display path) can stall without losing results.
- Also keeps running statistics over accepted results: the largest Z seen and its Y, an accepted-result count, and a sticky error flag for illegal run lengths.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- DATA_W, 8, width of the Y result.
- LEN_W, 4, width of the Z run length.
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream result pair is valid this cycle.
- in_ready  output  1  buffer can accept a pair this cycle.
- in_y  input  DATA_W  result Y from the upstream stage.
- in_z  input  LEN_W  run length Z from the upstream stage.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_y  output  DATA_W  head entry Y.
- out_z  output  LEN_W  head entry Z.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- clr_stats  input  1  synchronous clear of the statistics.
- max_z  output  LEN_W  largest Z accepted since the last clear.
- max_y  output  DATA_W  Y that accompanied max_z.
- total  output  CNT_W  number of accepted pairs, saturating.
- err_len  output  1  sticky flag: an accepted Z exceeded DATA_W.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Read and write pointers = 0; count = 0; stored contents discarded.
  - out_valid = 0, in_ready = 1, out_y = 0, out_z = 0.
  - max_z = 0, max_y = 0, total = 0, err_len = 0.
  - Release takes effect on the first rising clk edge after reset deasserts.
- Push: occurs when in_valid && in_ready. Writes {in_y, in_z} at the write pointer, then increments the write pointer modulo DEPTH.
- Pop: occurs when out_valid && out_ready. Increments the read pointer modulo DEPTH.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready. When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0). out_y/out_z show the entry at the read pointer (first-word fall-through from storage). When out_valid = 0, out_y/out_z hold 0.
- Latency: a pair pushed at edge N is visible on out_* after edge N when the FIFO was empty. Minimum in-to-out latency is 1 cycle.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
  - neither: unchanged
- Empty with in_valid and out_ready both high: only the push occurs; no pop, since out_valid = 0.
- Data on in_y/in_z when in_valid = 0, or when in_ready = 0, is ignored. Upstream must hold the pair until accepted.
- Statistics, evaluated on each accepted push:
  - If in_z > max_z (strictly), max_z ← in_z and max_y ← in_y. On ties the earlier entry is kept.
  - total ← total + 1, saturating at 2^CNT_W − 1.
  - If in_z > DATA_W (i.e. > 8), err_len ← 1. It stays set until clr_stats or reset. The entry is still stored and still participates in the max comparison.
- clr_stats:
  - Clears max_z, max_y, total and err_len on the next edge. FIFO contents and pointers are unaffected.
  - If clr_stats coincides with a push, statistics are cleared first and then the push is applied: max_z = in_z, max_y = in_y, total = 1, err_len = (in_z > DATA_W).
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally. Full and empty are distinguished by count, not by pointer equality.

Test Plan:
- Reset then idle: assert reset mid-stream with 3 entries held → count=0, out_valid=0, in_ready=1, all stats 0 immediately, without waiting for a clock edge.
- Fill to full with out_ready=0: push (Y,Z) = (0x0F,4), (0xFF,8), (0x01,1), (0x6E,3) → count=4, in_ready=0. A 5th push of (0xAA,1) is held off. Then pop four entries → exact order 0x0F/4, 0xFF/8, 0x01/1, 0x6E/3.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing Y → count stays 2, output order matches input order, pointers wrap at least twice.
- Max tracking: push Z sequence 2, 5 (Y=0x7C), 5 (Y=0x3E), 3 → max_z=5, max_y=0x7C (tie keeps first), total=4.
- Error/clear: push Z=9 → err_len=1. Then clr_stats together with a push of (0x06,2) → max_z=2, max_y=0x06, total=1, err_len=0.
- Empty pass-through: on an empty FIFO, push (0x80,1) with out_ready=1 held high → out_valid rises the next cycle with 0x80/1, pops that cycle, count returns to 0.
